// File: rtl/sort_scheduler_if.sv
// Handshake and data bundle between the sort scheduler and its neighbours:
// the packet source, the merge sorter and the modulator.
interface sort_scheduler_if #(
  parameter int PACKET_WIDTH    = 16,
  parameter int INDEX_WIDTH     = 4,
  parameter int PREAMBLE_LENGTH = 32
);
  localparam int SORTED_WIDTH = PACKET_WIDTH*(8+INDEX_WIDTH)+PREAMBLE_LENGTH;

  logic                         in_valid;
  logic                         in_ready;
  logic [PACKET_WIDTH-1:0][7:0] in_packet;
  logic [PACKET_WIDTH-1:0][7:0] sort_packet;
  logic                         sort_start;
  logic                         sort_reset;
  logic                         sort_done;
  logic [SORTED_WIDTH-1:0]      sorted_in;
  logic                         out_valid;
  logic                         out_ready;
  logic [SORTED_WIDTH-1:0]      out_sorted;
  logic                         timeout_pulse;
  logic [15:0]                  pkt_count;
  logic [7:0]                   timeout_count;

  modport master (
    input  in_valid, in_packet, sort_done, sorted_in, out_ready,
    output in_ready, sort_packet, sort_start, sort_reset, out_valid, out_sorted,
           timeout_pulse, pkt_count, timeout_count
  );

  modport slave (
    output in_valid, in_packet, sort_done, sorted_in, out_ready,
    input  in_ready, sort_packet, sort_start, sort_reset, out_valid, out_sorted,
           timeout_pulse, pkt_count, timeout_count
  );
endinterface

// File: rtl/sort_scheduler.sv
// Sequences one packet at a time through the merge sorter, with a watchdog
// that aborts and resets a sorter that never signals completion.
//
// state     | meaning
// IDLE      | ready for a packet from the source
// LAUNCH    | packet held, start strobe to the sorter
// WAIT_SORT | waiting for sorter done, watchdog running
// HOLD      | sorted word offered to the modulator
module sort_scheduler #(
  parameter int PACKET_WIDTH    = 16,
  parameter int INDEX_WIDTH     = 4,
  parameter int PREAMBLE_LENGTH = 32,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic              clk,
  input  logic              reset,
  sort_scheduler_if.master  bus
);
  localparam int SORTED_WIDTH = PACKET_WIDTH*(8+INDEX_WIDTH)+PREAMBLE_LENGTH;
  localparam int WD_W         = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_SORT, HOLD} state_t;

  state_t                       state, next_state;
  logic [WD_W-1:0]              wd_cnt;
  logic                         abort_q;
  logic                         in_ready_q, sort_start_q, out_valid_q, timeout_pulse_q;
  logic [PACKET_WIDTH-1:0][7:0] sort_packet_q;
  logic [SORTED_WIDTH-1:0]      out_sorted_q;
  logic [15:0]                  pkt_count_q;
  logic [7:0]                   timeout_count_q;
  logic                         accept, capture, abort, transfer;

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    transfer   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          accept     = 1'b1;
          next_state = LAUNCH;
        end
      end
      LAUNCH: next_state = WAIT_SORT;
      WAIT_SORT: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (bus.sort_done) begin
          capture    = 1'b1;
          next_state = HOLD;
        end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES-1)) begin
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          transfer   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      wd_cnt          <= '0;
      abort_q         <= 1'b0;
      in_ready_q      <= 1'b0;
      sort_start_q    <= 1'b0;
      out_valid_q     <= 1'b0;
      timeout_pulse_q <= 1'b0;
      sort_packet_q   <= '0;
      out_sorted_q    <= '0;
      pkt_count_q     <= '0;
      timeout_count_q <= '0;
    end else begin
      state           <= next_state;
      in_ready_q      <= (next_state == IDLE);
      sort_start_q    <= (next_state == LAUNCH);
      out_valid_q     <= (next_state == HOLD);
      abort_q         <= abort;
      timeout_pulse_q <= abort;
      if (state == LAUNCH)         wd_cnt <= '0;
      else if (state == WAIT_SORT) wd_cnt <= wd_cnt + 1'b1;
      if (accept)  sort_packet_q <= bus.in_packet;
      if (capture) out_sorted_q  <= bus.sorted_in;
      if (transfer) pkt_count_q  <= pkt_count_q + 16'd1;
      if (abort && timeout_count_q != 8'hFF) timeout_count_q <= timeout_count_q + 8'd1;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.sort_start    = sort_start_q;
  assign bus.sort_reset    = reset | abort_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.timeout_pulse = timeout_pulse_q;
  assign bus.sort_packet   = sort_packet_q;
  assign bus.out_sorted    = out_sorted_q;
  assign bus.pkt_count     = pkt_count_q;
  assign bus.timeout_count = timeout_count_q;
endmodule

// File: tb/tb_sort_scheduler.sv
// Self-checking bench for sort_scheduler: the bench plays source, sorter and
// modulator, and compares delivered words against a scoreboard queue.
module tb_sort_scheduler;
  localparam int PW = 16;
  localparam int IW = 4;
  localparam int PL = 32;
  localparam int TO = 8;
  localparam int SW = PW*(8+IW)+PL;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sort_scheduler_if #(.PACKET_WIDTH(PW), .INDEX_WIDTH(IW), .PREAMBLE_LENGTH(PL)) bus();

  sort_scheduler #(.PACKET_WIDTH(PW), .INDEX_WIDTH(IW), .PREAMBLE_LENGTH(PL),
                   .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_pkt = 0;
  int exp_to  = 0;
  logic [SW-1:0]   exp_q[$];
  logic [SW-1:0]   last_word = '0;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [SW-1:0] rand_word();
    logic [SW-1:0] w = '0;
    for (int i = 0; i < SW; i += 32) w = (w << 32) | SW'($urandom());
    return w;
  endfunction

  function automatic logic [PW*8-1:0] rand_pkt();
    logic [PW*8-1:0] p = '0;
    for (int i = 0; i < PW*8; i += 32) p = (p << 32) | (PW*8)'($urandom());
    return p;
  endfunction

  task automatic accept(input logic [PW*8-1:0] pkt);
    int n = 0;
    bus.in_valid  = 1'b1;
    bus.in_packet = pkt;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check_val("accept_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check_val("start_strobe", bus.sort_start, 1);
    check_val("sort_packet", bus.sort_packet, pkt);
    check_val("busy_ready", bus.in_ready, 0);
  endtask

  task automatic finish_sort(input int done_dly, input logic [SW-1:0] word,
                             input int ready_dly, input bit verbose);
    for (int j = 1; j < done_dly; j++) begin
      tick();
      if (verbose) begin
        check_val("start_once", bus.sort_start, 0);
        check_val("wait_valid", bus.out_valid, 0);
        check_val("wait_ready", bus.in_ready, 0);
      end
    end
    bus.sort_done = 1'b1;
    bus.sorted_in = word;
    exp_q.push_back(word);
    tick();
    bus.sort_done = 1'b0;
    bus.sorted_in = ~word;
    check_val("hold_valid", bus.out_valid, 1);
    check_val("no_timeout", bus.timeout_pulse, 0);
    for (int j = 0; j < ready_dly; j++) begin
      check_val("stall_valid", bus.out_valid, 1);
      check_val("stall_word", bus.out_sorted, word);
      check_val("stall_ready", bus.in_ready, 0);
      tick();
    end
    bus.out_ready = 1'b1;
    if (exp_q.size() == 0) check_val("sb_empty", 1, 0);
    else check_val("sb_word", bus.out_sorted, exp_q.pop_front());
    last_word = word;
    tick();
    bus.out_ready = 1'b0;
    exp_pkt = (exp_pkt + 1) & 16'hFFFF;
    check_val("post_valid", bus.out_valid, 0);
    check_val("post_ready", bus.in_ready, 1);
    check_val("pkt_count", bus.pkt_count, exp_pkt);
  endtask

  task automatic run_timeout(input bit verbose);
    accept(rand_pkt());
    for (int j = 1; j <= TO; j++) begin
      tick();
      if (verbose) begin
        check_val("wd_pulse_early", bus.timeout_pulse, 0);
        check_val("wd_reset_early", bus.sort_reset, 0);
      end
    end
    tick();
    exp_to = (exp_to < 255) ? exp_to + 1 : 255;
    check_val("wd_pulse", bus.timeout_pulse, 1);
    check_val("wd_sort_reset", bus.sort_reset, 1);
    check_val("wd_idle_ready", bus.in_ready, 1);
    check_val("wd_valid", bus.out_valid, 0);
    check_val("timeout_count", bus.timeout_count, exp_to);
    tick();
    check_val("wd_pulse_end", bus.timeout_pulse, 0);
    check_val("wd_reset_end", bus.sort_reset, 0);
  endtask

  initial begin
    #500us;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    logic [PW*8-1:0] pkt;
    bus.in_valid  = 1'b0;
    bus.in_packet = '0;
    bus.sort_done = 1'b0;
    bus.sorted_in = '0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    check_val("rst_ready", bus.in_ready, 0);
    check_val("rst_sort_reset", bus.sort_reset, 1);
    check_val("rst_valid", bus.out_valid, 0);
    reset = 1'b0;
    tick();
    check_val("rel_ready", bus.in_ready, 1);
    check_val("rel_start", bus.sort_start, 0);
    check_val("rel_sort_reset", bus.sort_reset, 0);
    check_val("rel_valid", bus.out_valid, 0);
    check_val("rel_pulse", bus.timeout_pulse, 0);
    check_val("rel_sorted", bus.out_sorted, 0);
    check_val("rel_counts", {bus.pkt_count, bus.timeout_count}, 0);

    // basic transfer, done five cycles after accept
    for (int i = 0; i < PW; i++) pkt[i*8 +: 8] = 8'(i);
    bus.out_ready = 1'b1;
    accept(pkt);
    bus.out_ready = 1'b0;
    finish_sort(5, rand_word(), 0, 1'b1);

    // modulator back-pressure
    accept(rand_pkt());
    finish_sort(3, rand_word(), 10, 1'b1);

    // watchdog abort
    run_timeout(1'b1);

    // done coincident with the last watchdog cycle
    accept(rand_pkt());
    finish_sort(TO + 1, rand_word(), 0, 1'b1);
    check_val("coinc_tcount", bus.timeout_count, exp_to);

    // stray done while idle
    bus.sort_done = 1'b1;
    bus.sorted_in = rand_word();
    tick();
    bus.sort_done = 1'b0;
    check_val("stray_valid", bus.out_valid, 0);
    check_val("stray_ready", bus.in_ready, 1);
    check_val("stray_word", bus.out_sorted, last_word);
    check_val("stray_pkt", bus.pkt_count, exp_pkt);
    check_val("stray_pulse", bus.timeout_pulse, 0);

    // reset while waiting on the sorter
    accept(rand_pkt());
    tick();
    reset = 1'b1;
    #1;
    check_val("mid_sort_reset", bus.sort_reset, 1);
    tick();
    exp_pkt = 0;
    exp_to  = 0;
    check_val("mid_ready", bus.in_ready, 0);
    check_val("mid_valid", bus.out_valid, 0);
    check_val("mid_packet", bus.sort_packet, 0);
    check_val("mid_counts", {bus.pkt_count, bus.timeout_count}, 0);
    reset = 1'b0;
    tick();
    check_val("mid_rel_ready", bus.in_ready, 1);

    // reset while holding a sorted word
    accept(rand_pkt());
    tick();
    bus.sort_done = 1'b1;
    bus.sorted_in = rand_word();
    tick();
    bus.sort_done = 1'b0;
    check_val("hold_rst_valid", bus.out_valid, 1);
    reset = 1'b1;
    tick();
    check_val("hold_rst_valid0", bus.out_valid, 0);
    check_val("hold_rst_word", bus.out_sorted, 0);
    reset = 1'b0;
    tick();
    check_val("hold_rel_ready", bus.in_ready, 1);

    // back-to-back throughput
    for (int i = 0; i < 300; i++) begin
      accept(rand_pkt());
      finish_sort(2, rand_word(), 0, 1'b0);
    end
    check_val("pkt_300", bus.pkt_count, 300);

    // timeout counter saturation
    for (int i = 0; i < 260; i++) run_timeout(1'b0);
    check_val("tcount_sat", bus.timeout_count, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
